// File: rtl/uart_tx_if.sv
// Handshake and per-frame configuration bundle between the TX FIFO read side and uart_tx_engine.
interface uart_tx_if #(
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned DIV_W     = 16
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic [DIV_W-1:0]     baud_div;
   logic                 parity_en;
   logic                 parity_odd;
   logic                 stop2;

   modport master (
      output tx_data, tx_valid, baud_div, parity_en, parity_odd, stop2,
      input  tx_ready
   );

   modport slave (
      input  tx_data, tx_valid, baud_div, parity_en, parity_odd, stop2,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_engine.sv
// Parametrised UART transmitter: start + DATA_BITS (LSB first) + optional parity + 1/2 stop bits,
// runtime baud divisor; all frame configuration is captured on accept.
module uart_tx_engine #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned DIV_W      = 16,
   parameter bit          IDLE_LEVEL = 1'b1
) (
   input  logic     clk,
   input  logic     rst,
   uart_tx_if.slave bus,
   output logic     tx,
   output logic     busy,
   output logic     tx_done
);

   localparam int unsigned      CNT_W    = $clog2(DATA_BITS + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_engine: DATA_BITS must be in 5..9");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [DIV_W-1:0]     timer_q, timer_d;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DIV_W-1:0]     div_q;
   logic                 par_en_q;
   logic                 parity_q;
   logic                 stop2_q;
   logic                 ready_q;
   logic                 tx_d, ready_d, busy_d, done_d;
   logic                 accept;
   logic                 bit_end;

   assign bus.tx_ready = ready_q;
   assign accept       = bus.tx_valid && ready_q;
   assign bit_end      = (timer_q == div_q - DIV_ONE);

   // State, datapath and registered outputs; reset drops the line to idle immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_cnt_q <= '0;
         shreg_q   <= '0;
         div_q     <= DIV_ONE;
         par_en_q  <= 1'b0;
         parity_q  <= 1'b0;
         stop2_q   <= 1'b0;
         ready_q   <= 1'b1;
         tx        <= IDLE_LEVEL;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         ready_q   <= ready_d;
         tx        <= tx_d;
         busy      <= busy_d;
         tx_done   <= done_d;
         if (accept) begin
            div_q    <= (bus.baud_div == '0) ? DIV_ONE : bus.baud_div;
            par_en_q <= bus.parity_en;
            parity_q <= (^bus.tx_data) ^ bus.parity_odd;
            stop2_q  <= bus.stop2;
         end
      end
   end

   // Next-state: timer runs 0..div-1 per bit, bit counter reused for the second stop bit.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d   = S_START;
               timer_d   = '0;
               bit_cnt_d = '0;
               shreg_d   = bus.tx_data;
            end
         end
         S_START: begin
            timer_d = bit_end ? '0 : timer_q + DIV_ONE;
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            timer_d = bit_end ? '0 : timer_q + DIV_ONE;
            if (bit_end) begin
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  state_d   = par_en_q ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_ONE;
                  shreg_d   = shreg_q >> 1;
               end
            end
         end
         S_PARITY: begin
            timer_d = bit_end ? '0 : timer_q + DIV_ONE;
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            timer_d = bit_end ? '0 : timer_q + DIV_ONE;
            if (bit_end) begin
               if (stop2_q && bit_cnt_q == '0) begin
                  bit_cnt_d = CNT_ONE;
               end else begin
                  bit_cnt_d = '0;
                  state_d   = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode from the upcoming state so every output is a flop.
   always_comb begin
      tx_d    = IDLE_LEVEL;
      ready_d = (state_d == S_IDLE);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_q == S_STOP) && (state_d == S_IDLE);
      unique case (state_d)
         S_START:  tx_d = ~IDLE_LEVEL;
         S_DATA:   tx_d = shreg_d[0];
         S_PARITY: tx_d = parity_q;
         default:  tx_d = IDLE_LEVEL;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: per-cycle line scoreboard on an 8-bit instance,
// inline waveform check on a 7-bit odd-parity two-stop instance.
module tb_uart_tx_engine;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_tx_if #(.DATA_BITS(8), .DIV_W(16)) if8 ();
   uart_tx_if #(.DATA_BITS(7), .DIV_W(16)) if7 ();

   logic tx8, busy8, done8;
   logic tx7, busy7, done7;

   uart_tx_engine #(.DATA_BITS(8), .DIV_W(16), .IDLE_LEVEL(1'b1)) u8 (
      .clk(clk), .rst(rst), .bus(if8), .tx(tx8), .busy(busy8), .tx_done(done8)
   );

   uart_tx_engine #(.DATA_BITS(7), .DIV_W(16), .IDLE_LEVEL(1'b1)) u7 (
      .clk(clk), .rst(rst), .bus(if7), .tx(tx7), .busy(busy7), .tx_done(done7)
   );

   int   total   = 0;
   int   bad     = 0;
   int   cyc_cnt = 0;
   int   n_done  = 0;
   logic exp_q[$];
   logic done_exp = 1'b0;
   int   mon_sz;
   logic mon_e;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Expected per-cycle line level for one 8-bit frame, built from the configuration at accept.
   function automatic void push_frame(input logic [7:0] d, input logic [15:0] div,
                                      input logic pe, input logic po, input logic s2);
      int   n;
      logic p;
      n = (div == 16'd0) ? 1 : int'(div);
      p = (^d) ^ po;
      for (int i = 0; i < n; i++) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
         for (int i = 0; i < n; i++) exp_q.push_back(d[b]);
      if (pe) for (int i = 0; i < n; i++) exp_q.push_back(p);
      for (int i = 0; i < (s2 ? 2 : 1) * n; i++) exp_q.push_back(1'b1);
   endfunction

   // Scoreboard for the 8-bit instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         done_exp = 1'b0;
      end else begin
         mon_sz = exp_q.size();
         total++;
         if (if8.tx_ready !== (mon_sz == 0)) begin
            bad++;
            $display("FAIL sb_ready t=%0t: got %b want %b", $time, if8.tx_ready, (mon_sz == 0));
         end
         total++;
         if (busy8 !== (mon_sz != 0)) begin
            bad++;
            $display("FAIL sb_busy t=%0t: got %b want %b", $time, busy8, (mon_sz != 0));
         end
         mon_e = (mon_sz != 0) ? exp_q.pop_front() : 1'b1;
         total++;
         if (tx8 !== mon_e) begin
            bad++;
            $display("FAIL sb_tx t=%0t: got %b want %b", $time, tx8, mon_e);
         end
         total++;
         if (done8 !== done_exp) begin
            bad++;
            $display("FAIL sb_done t=%0t: got %b want %b", $time, done8, done_exp);
         end
         if (done8 === 1'b1) n_done++;
         done_exp = (mon_sz == 1);
         if (if8.tx_valid === 1'b1 && mon_sz == 0)
            push_frame(if8.tx_data, if8.baud_div, if8.parity_en, if8.parity_odd, if8.stop2);
      end
   end

   // Send one word on the 8-bit instance and check accept-to-done frame length.
   task automatic send8(input logic [7:0] d, input logic [15:0] div, input logic pe,
                        input logic po, input logic s2, input int exp_len,
                        input int chg_at, input logic [15:0] chg_div, input string name);
      int k;
      @(posedge clk); #1;
      if8.tx_data    = d;
      if8.baud_div   = div;
      if8.parity_en  = pe;
      if8.parity_odd = po;
      if8.stop2      = s2;
      if8.tx_valid   = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (if8.tx_ready !== 1'b1 && k < 500);
      @(posedge clk); #1;
      if8.tx_valid = 1'b0;
      k = 0;
      while (k < 2000) begin
         @(negedge clk);
         k++;
         if (k == chg_at) if8.baud_div = chg_div;
         if (done8 === 1'b1) break;
      end
      total++;
      if (k - 1 != exp_len) begin
         bad++;
         $display("FAIL %s_len: got %0d cycles want %0d", name, k - 1, exp_len);
      end
   endtask

   task automatic test_reset();
      if8.tx_valid = 1'b0; if8.tx_data = '0; if8.baud_div = 16'd4;
      if8.parity_en = 1'b0; if8.parity_odd = 1'b0; if8.stop2 = 1'b0;
      if7.tx_valid = 1'b0; if7.tx_data = '0; if7.baud_div = 16'd2;
      if7.parity_en = 1'b0; if7.parity_odd = 1'b0; if7.stop2 = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({tx8, if8.tx_ready, busy8, done8} !== 4'b1100) begin
         bad++;
         $display("FAIL reset8: got tx/rdy/busy/done=%b want 1100", {tx8, if8.tx_ready, busy8, done8});
      end
      total++;
      if ({tx7, if7.tx_ready, busy7, done7} !== 4'b1100) begin
         bad++;
         $display("FAIL reset7: got tx/rdy/busy/done=%b want 1100", {tx7, if7.tx_ready, busy7, done7});
      end
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_8n1();
      int n0;
      n0 = n_done;
      send8(8'hA5, 16'd4, 1'b0, 1'b0, 1'b0, 40, -1, 16'd0, "8n1");
      repeat (4) @(posedge clk);
      total++;
      if (n_done - n0 != 1) begin
         bad++;
         $display("FAIL 8n1_done_count: got %0d want 1", n_done - n0);
      end
   endtask

   task automatic test_parity();
      send8(8'hA5, 16'd3, 1'b1, 1'b0, 1'b0, 33, -1, 16'd0, "8e1");
      send8(8'hA5, 16'd3, 1'b1, 1'b1, 1'b0, 33, -1, 16'd0, "8o1");
      send8(8'h07, 16'd2, 1'b1, 1'b0, 1'b1, 24, -1, 16'd0, "8e2");
   endtask

   task automatic test_7o2();
      logic [6:0] d;
      logic       exp[$];
      int         k;
      d = 7'h35;
      for (int i = 0; i < 2; i++) exp.push_back(1'b0);
      for (int b = 0; b < 7; b++) for (int i = 0; i < 2; i++) exp.push_back(d[b]);
      for (int i = 0; i < 2; i++) exp.push_back((^d) ^ 1'b1);
      for (int i = 0; i < 4; i++) exp.push_back(1'b1);
      @(posedge clk); #1;
      if7.tx_data = d; if7.baud_div = 16'd2; if7.parity_en = 1'b1;
      if7.parity_odd = 1'b1; if7.stop2 = 1'b1; if7.tx_valid = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (if7.tx_ready !== 1'b1 && k < 500);
      @(posedge clk); #1;
      if7.tx_valid = 1'b0;
      for (int i = 0; i < exp.size(); i++) begin
         @(negedge clk);
         total++;
         if (tx7 !== exp[i] || busy7 !== 1'b1 || done7 !== 1'b0) begin
            bad++;
            $display("FAIL 7o2_bit%0d: got tx=%b busy=%b done=%b want tx=%b busy=1 done=0",
                     i, tx7, busy7, done7, exp[i]);
         end
      end
      @(negedge clk);
      total++;
      if ({tx7, if7.tx_ready, done7} !== 3'b111) begin
         bad++;
         $display("FAIL 7o2_end: got tx/rdy/done=%b want 111", {tx7, if7.tx_ready, done7});
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] w[3];
      int         t[3];
      int         k;
      int         n0;
      w[0] = 8'h3C; w[1] = 8'hC3; w[2] = 8'h7E;
      n0 = n_done;
      @(posedge clk); #1;
      if8.baud_div = 16'd5; if8.parity_en = 1'b0; if8.parity_odd = 1'b0; if8.stop2 = 1'b0;
      if8.tx_data = w[0]; if8.tx_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         k = 0;
         do begin @(negedge clk); k++; end while (if8.tx_ready !== 1'b1 && k < 500);
         t[i] = cyc_cnt;
         @(posedge clk); #1;
         if (i < 2) if8.tx_data = w[i + 1];
         else       if8.tx_valid = 1'b0;
      end
      for (int i = 1; i < 3; i++) begin
         total++;
         if (t[i] - t[i - 1] != 51) begin
            bad++;
            $display("FAIL b2b_spacing%0d: got %0d want 51", i, t[i] - t[i - 1]);
         end
      end
      repeat (55) @(posedge clk);
      total++;
      if (n_done - n0 != 3) begin
         bad++;
         $display("FAIL b2b_done_count: got %0d want 3", n_done - n0);
      end
   endtask

   task automatic test_reset_mid_frame();
      int k;
      @(posedge clk); #1;
      if8.tx_data = 8'hA5; if8.baud_div = 16'd4; if8.parity_en = 1'b0;
      if8.parity_odd = 1'b0; if8.stop2 = 1'b0; if8.tx_valid = 1'b1;
      k = 0;
      do begin @(negedge clk); k++; end while (if8.tx_ready !== 1'b1 && k < 500);
      @(posedge clk); #1;
      if8.tx_valid = 1'b0;
      repeat (18) @(posedge clk);
      #2;
      total++;
      if (tx8 !== 1'b0) begin
         bad++;
         $display("FAIL rstmid_bit3: got %b want 0", tx8);
      end
      rst = 1'b1;
      #1;
      total++;
      if ({tx8, if8.tx_ready, busy8, done8} !== 4'b1100) begin
         bad++;
         $display("FAIL rstmid_async: got tx/rdy/busy/done=%b want 1100", {tx8, if8.tx_ready, busy8, done8});
      end
      @(negedge clk);
      @(posedge clk); #2;
      rst = 1'b0;
      repeat (5) @(posedge clk);
      send8(8'h5A, 16'd4, 1'b0, 1'b0, 1'b0, 40, -1, 16'd0, "rstmid_next");
   endtask

   task automatic test_baud_change();
      send8(8'h81, 16'd0, 1'b0, 1'b0, 1'b0, 10, -1, 16'd0, "div0");
      send8(8'h66, 16'd3, 1'b0, 1'b0, 1'b0, 30, 5, 16'd7, "divchg_cur");
      send8(8'h99, 16'd7, 1'b0, 1'b0, 1'b0, 70, -1, 16'd0, "divchg_next");
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_parity();
      test_7o2();
      test_back_to_back();
      test_reset_mid_frame();
      test_baud_change();
      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
